// File: rtl/controlador_sequenciador_pkg.sv
// sap1_pkg: shared definitions for the SAP-1 controller/sequencer.
//   - opcode constants (LDA, ADD, SUB, OUT, HLT)
//   - one-hot T-state encoding (T1 = bit0 ... T6 = bit5)
//   - bit positions inside the 12-bit control word
//     {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo} = bits 11..0
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_W = 12;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_estado_e;

    localparam int B_CP = 11;
    localparam int B_EP = 10;
    localparam int B_LM = 9;
    localparam int B_CE = 8;
    localparam int B_LI = 7;
    localparam int B_EI = 6;
    localparam int B_LA = 5;
    localparam int B_EA = 4;
    localparam int B_SU = 3;
    localparam int B_EU = 2;
    localparam int B_LB = 1;
    localparam int B_LO = 0;

endpackage

// File: rtl/controlador_sequenciador_if.sv
// controlador_sequenciador_if: bundle between the sequencer and its user.
//   run_prog          1 = execute, 0 = programming mode (sequencer frozen)
//   opcode            IR upper nibble, stable during T4..T6
//   palavra_controle  active-high control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//   estado_t          one-hot T-state (bit0 = T1 ... bit5 = T6)
//   ciclo_fim         high in the last T-state of the instruction
//   halt              sticky after HLT until reset
// master = the side driving run_prog/opcode; slave = the sequencer.
interface controlador_sequenciador_if
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4
);
    logic                run_prog;
    logic [OPCODE_W-1:0] opcode;
    logic [CW_W-1:0]     palavra_controle;
    logic [5:0]          estado_t;
    logic                ciclo_fim;
    logic                halt;

    modport master (
        output run_prog, opcode,
        input  palavra_controle, estado_t, ciclo_fim, halt
    );

    modport slave (
        input  run_prog, opcode,
        output palavra_controle, estado_t, ciclo_fim, halt
    );
endinterface

// File: rtl/controlador_sequenciador_contador_anel.sv
// contador_anel: 6-bit one-hot ring counter T1 -> ... -> T6 -> T1.
//   clk_in            rising-edge clock
//   limpar_iniciar_n  asynchronous active-low reset, forces T1
//   habilita          advance enable
//   volta_t1          synchronous return to T1 (takes effect only when enabled)
//   estado            current one-hot T-state
module contador_anel
    import sap1_pkg::*;
(
    input  logic      clk_in,
    input  logic      limpar_iniciar_n,
    input  logic      habilita,
    input  logic      volta_t1,
    output t_estado_e estado
);

    always_ff @(posedge clk_in or negedge limpar_iniciar_n) begin
        if (!limpar_iniciar_n) begin
            estado <= T1;
        end else if (habilita) begin
            if (volta_t1) begin
                estado <= T1;
            end else begin
                case (estado)
                    T1:      estado <= T2;
                    T2:      estado <= T3;
                    T3:      estado <= T4;
                    T4:      estado <= T5;
                    T5:      estado <= T6;
                    T6:      estado <= T1;
                    default: estado <= T1;
                endcase
            end
        end
    end

endmodule

// File: rtl/controlador_sequenciador.sv
// controlador_sequenciador: SAP-1 control unit (ring counter + control decode).
//   clk_in            rising-edge clock
//   limpar_iniciar_n  asynchronous active-low reset (only exit from halt)
//   bus (slave)       run_prog, opcode in; palavra_controle, estado_t,
//                     ciclo_fim, halt out
// Build option: define CICLO_VARIAVEL_EN for a variable-length machine cycle
// (LDA ends in T5, OUT/NOP in T4, ADD/SUB in T6); otherwise every
// instruction occupies T1..T6.
module controlador_sequenciador
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input logic                       clk_in,
    input logic                       limpar_iniciar_n,
    controlador_sequenciador_if.slave bus
);

    logic [OPCODE_W-1:0] op;
    logic                is_lda, is_add, is_sub, is_out, is_hlt;
    t_estado_e           estado;
    logic                halt_q;
    logic                ativo;
    logic                parada_t4;
    logic                ultimo;
    logic [CW_W-1:0]     palavra;

    assign op     = bus.opcode;
    assign is_lda = (op == OPCODE_W'(OP_LDA));
    assign is_add = (op == OPCODE_W'(OP_ADD));
    assign is_sub = (op == OPCODE_W'(OP_SUB));
    assign is_out = (op == OPCODE_W'(OP_OUT));
    assign is_hlt = (op == OPCODE_W'(OP_HLT));

    // Reset level is included so outputs go quiet the instant reset asserts,
    // not only after the counter register has been cleared.
    assign ativo     = limpar_iniciar_n && bus.run_prog && !halt_q;
    assign parada_t4 = (estado == T4) && is_hlt;

`ifdef CICLO_VARIAVEL_EN
    always_comb begin
        ultimo = 1'b0;
        if (is_add || is_sub) begin
            ultimo = (estado == T6);
        end else if (is_lda) begin
            ultimo = (estado == T5);
        end else if (!is_hlt) begin
            ultimo = (estado == T4);
        end
    end
`else
    assign ultimo = (estado == T6) && !is_hlt;
`endif

    contador_anel u_contador_anel (
        .clk_in           (clk_in),
        .limpar_iniciar_n (limpar_iniciar_n),
        .habilita         (ativo && !parada_t4),
        .volta_t1         (ultimo),
        .estado           (estado)
    );

    // HLT freezes the counter in T4; halt is set on the edge that would have
    // ended T4 and stays set until reset.
    always_ff @(posedge clk_in or negedge limpar_iniciar_n) begin
        if (!limpar_iniciar_n) begin
            halt_q <= 1'b0;
        end else if (ativo && parada_t4) begin
            halt_q <= 1'b1;
        end
    end

    always_comb begin
        palavra = '0;
        case (estado)
            T1: begin
                palavra[B_EP] = 1'b1;
                palavra[B_LM] = 1'b1;
            end
            T2: palavra[B_CP] = 1'b1;
            T3: begin
                palavra[B_CE] = 1'b1;
                palavra[B_LI] = 1'b1;
            end
            T4: begin
                if (is_lda || is_add || is_sub) begin
                    palavra[B_EI] = 1'b1;
                    palavra[B_LM] = 1'b1;
                end else if (is_out) begin
                    palavra[B_EA] = 1'b1;
                    palavra[B_LO] = 1'b1;
                end
            end
            T5: begin
                if (is_lda) begin
                    palavra[B_CE] = 1'b1;
                    palavra[B_LA] = 1'b1;
                end else if (is_add || is_sub) begin
                    palavra[B_CE] = 1'b1;
                    palavra[B_LB] = 1'b1;
                end
            end
            T6: begin
                if (is_add || is_sub) begin
                    palavra[B_EU] = 1'b1;
                    palavra[B_LA] = 1'b1;
                    palavra[B_SU] = is_sub;
                end
            end
            default: palavra = '0;
        endcase
    end

    assign bus.palavra_controle = ativo ? palavra : '0;
    assign bus.ciclo_fim        = ativo && ultimo;
    assign bus.estado_t         = estado;
    assign bus.halt             = halt_q;

endmodule

// File: tb/tb_controlador_sequenciador.sv
module tb_controlador_sequenciador;

    localparam logic [11:0] CP = 12'h800, EP = 12'h400, LM = 12'h200, CE = 12'h100;
    localparam logic [11:0] LI = 12'h080, EI = 12'h040, LA = 12'h020, EA = 12'h010;
    localparam logic [11:0] SU = 12'h008, EU = 12'h004, LB = 12'h002, LO = 12'h001;
    localparam logic [3:0]  LDA = 4'b0000, ADD = 4'b0001, SUB = 4'b0010;
    localparam logic [3:0]  OUTI = 4'b1110, HLT = 4'b1111;
`ifdef CICLO_VARIAVEL_EN
    localparam logic VAR = 1'b1;
`else
    localparam logic VAR = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic limpar_iniciar_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   m_k = 0;       // model: index of current T-state within the instruction
    logic m_h = 1'b0;    // model: halted

    controlador_sequenciador_if #(.OPCODE_W(4)) bus ();

    controlador_sequenciador #(.OPCODE_W(4)) dut (
        .clk_in           (clk_in),
        .limpar_iniciar_n (limpar_iniciar_n),
        .bus              (bus)
    );

    always #5 clk_in = ~clk_in;

    function automatic int inst_len(logic [3:0] op);
        int n;
        n = 6;
`ifdef CICLO_VARIAVEL_EN
        if (op == LDA) n = 5;
        else if (op != ADD && op != SUB) n = 4;
`endif
        return n;
    endfunction

    function automatic logic [11:0] step_word(int k, logic [3:0] op);
        logic [11:0] w;
        w = 12'h000;
        case (k)
            0: w = EP | LM;
            1: w = CP;
            2: w = CE | LI;
            3: if (op == LDA || op == ADD || op == SUB) w = EI | LM;
               else if (op == OUTI) w = EA | LO;
            4: if (op == LDA) w = CE | LA;
               else if (op == ADD || op == SUB) w = CE | LB;
            5: if (op == ADD) w = EU | LA;
               else if (op == SUB) w = EU | LA | SU;
            default: w = 12'h000;
        endcase
        return w;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Reference model: step index advances per executed cycle, wrapping at the
    // instruction length; HLT stops at step 3 and latches halt.
    always @(posedge clk_in or negedge limpar_iniciar_n) begin
        if (!limpar_iniciar_n) begin
            m_k <= 0;
            m_h <= 1'b0;
        end else if (bus.run_prog && !m_h) begin
            if (bus.opcode == HLT && m_k == 3) m_h <= 1'b1;
            else if (m_k + 1 >= inst_len(bus.opcode)) m_k <= 0;
            else m_k <= m_k + 1;
        end
    end

    task automatic compare_loop();
        logic        act;
        logic [11:0] ew;
        logic        ecf;
        logic [5:0]  es;
        forever begin
            @(negedge clk_in);
            act = limpar_iniciar_n && bus.run_prog && !m_h;
            ew  = act ? step_word(m_k, bus.opcode) : 12'h000;
            ecf = act && (m_k == inst_len(bus.opcode) - 1) && (bus.opcode != HLT);
            es  = 6'b000001 << m_k;
            check("model.estado_t", 32'(bus.estado_t), 32'(es));
            check("model.palavra", 32'(bus.palavra_controle), 32'(ew));
            check("model.ciclo_fim", 32'(bus.ciclo_fim), 32'(ecf));
            check("model.halt", 32'(bus.halt), 32'(m_h));
            check("model.one_bus_driver",
                  32'($countones(bus.palavra_controle & (EP | CE | EI | EA | EU)) <= 1), 32'(1));
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(string n, logic [5:0] es, logic [11:0] w, logic cf, logic h);
        @(negedge clk_in);
        check({n, ".estado_t"}, 32'(bus.estado_t), 32'(es));
        check({n, ".palavra"}, 32'(bus.palavra_controle), 32'(w));
        check({n, ".ciclo_fim"}, 32'(bus.ciclo_fim), 32'(cf));
        check({n, ".halt"}, 32'(bus.halt), 32'(h));
    endtask

    task automatic chk_now(string n);
        check({n, ".estado_t"}, 32'(bus.estado_t), 32'(6'b000001));
        check({n, ".palavra"}, 32'(bus.palavra_controle), 32'(0));
        check({n, ".ciclo_fim"}, 32'(bus.ciclo_fim), 32'(0));
        check({n, ".halt"}, 32'(bus.halt), 32'(0));
    endtask

    initial begin
        bus.run_prog = 1'b1;
        bus.opcode   = ADD;
        fork
            compare_loop();
        join_none

        cyc();
        chk("reset", 6'b000001, 12'h000, 1'b0, 1'b0);

        // ADD, full instruction
        cyc();
        limpar_iniciar_n = 1'b1;
        chk("add_t1", 6'b000001, 12'h600, 1'b0, 1'b0);
        chk("add_t2", 6'b000010, 12'h800, 1'b0, 1'b0);
        chk("add_t3", 6'b000100, 12'h180, 1'b0, 1'b0);
        chk("add_t4", 6'b001000, 12'h240, 1'b0, 1'b0);
        chk("add_t5", 6'b010000, 12'h102, 1'b0, 1'b0);
        chk("add_t6", 6'b100000, 12'h024, 1'b1, 1'b0);

        // SUB
        cyc();
        bus.opcode = SUB;
        chk("sub_t1", 6'b000001, 12'h600, 1'b0, 1'b0);
        chk("sub_t2", 6'b000010, 12'h800, 1'b0, 1'b0);
        chk("sub_t3", 6'b000100, 12'h180, 1'b0, 1'b0);
        chk("sub_t4", 6'b001000, 12'h240, 1'b0, 1'b0);
        chk("sub_t5", 6'b010000, 12'h102, 1'b0, 1'b0);
        chk("sub_t6", 6'b100000, 12'h02C, 1'b1, 1'b0);

        // HLT: freezes in T4, sticky until reset
        cyc();
        bus.opcode = HLT;
        chk("hlt_t1", 6'b000001, 12'h600, 1'b0, 1'b0);
        chk("hlt_t2", 6'b000010, 12'h800, 1'b0, 1'b0);
        chk("hlt_t3", 6'b000100, 12'h180, 1'b0, 1'b0);
        chk("hlt_t4", 6'b001000, 12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) chk("hlt_held", 6'b001000, 12'h000, 1'b0, 1'b1);
        cyc();
        limpar_iniciar_n = 1'b0;
        #1;
        chk_now("hlt_async_reset");
        chk("hlt_reset", 6'b000001, 12'h000, 1'b0, 1'b0);

        // run_prog dropped in T3 for 5 cycles
        cyc();
        limpar_iniciar_n = 1'b1;
        bus.opcode = ADD;
        chk("run_t1", 6'b000001, 12'h600, 1'b0, 1'b0);
        chk("run_t2", 6'b000010, 12'h800, 1'b0, 1'b0);
        cyc();
        bus.run_prog = 1'b0;
        for (int i = 0; i < 5; i++) chk("run_frozen", 6'b000100, 12'h000, 1'b0, 1'b0);
        cyc();
        bus.run_prog = 1'b1;
        chk("run_resume_t3", 6'b000100, 12'h180, 1'b0, 1'b0);
        chk("run_resume_t4", 6'b001000, 12'h240, 1'b0, 1'b0);
        chk("run_resume_t5", 6'b010000, 12'h102, 1'b0, 1'b0);

        // reset in the middle of T5
        #2;
        limpar_iniciar_n = 1'b0;
        #1;
        chk_now("t5_async_reset");
        cyc();
        limpar_iniciar_n = 1'b1;
        bus.opcode = OUTI;
        chk("after_reset_t1", 6'b000001, 12'h600, 1'b0, 1'b0);

        // OUT
        chk("out_t2", 6'b000010, 12'h800, 1'b0, 1'b0);
        chk("out_t3", 6'b000100, 12'h180, 1'b0, 1'b0);
        chk("out_t4", 6'b001000, 12'h011, VAR, 1'b0);
`ifndef CICLO_VARIAVEL_EN
        chk("out_t5", 6'b010000, 12'h000, 1'b0, 1'b0);
        chk("out_t6", 6'b100000, 12'h000, 1'b1, 1'b0);
`endif
        chk("out_next_t1", 6'b000001, 12'h600, 1'b0, 1'b0);

        // LDA
        cyc();
        bus.opcode = LDA;
        chk("lda_t2", 6'b000010, 12'h800, 1'b0, 1'b0);
        chk("lda_t3", 6'b000100, 12'h180, 1'b0, 1'b0);
        chk("lda_t4", 6'b001000, 12'h240, 1'b0, 1'b0);
        chk("lda_t5", 6'b010000, 12'h120, VAR, 1'b0);
`ifdef CICLO_VARIAVEL_EN
        chk("lda_next_t1", 6'b000001, 12'h600, 1'b0, 1'b0);
`else
        chk("lda_t6", 6'b100000, 12'h000, 1'b1, 1'b0);
`endif

        // Randomized phase, checked every cycle by compare_loop
        for (int n = 0; n < 3000; n++) begin
            cyc();
            limpar_iniciar_n = 1'b1;
            bus.run_prog = ($urandom_range(0, 7) != 0);
            if (m_k <= 2 && !m_h && $urandom_range(0, 1) == 1) begin
                case ($urandom_range(0, 5))
                    0: bus.opcode = LDA;
                    1: bus.opcode = ADD;
                    2: bus.opcode = SUB;
                    3: bus.opcode = OUTI;
                    4: bus.opcode = ($urandom_range(0, 3) == 0) ? HLT : ADD;
                    default: bus.opcode = 4'($urandom_range(0, 15));
                endcase
            end
            if ((m_h && $urandom_range(0, 15) == 0) || $urandom_range(0, 299) == 0) begin
                limpar_iniciar_n = 1'b0;
            end
        end

        cyc();
        limpar_iniciar_n = 1'b1;
        @(negedge clk_in);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
